// File: rtl/csm_pkg.sv
// Shared types and defaults for the CSM dual-port shared memory.
`timescale 1ns/1ps
package csm_pkg;

  localparam int unsigned CSM_ADDR_W = 2;
  localparam int unsigned CSM_DATA_W = 8;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_READ    = 3'd1,
    OP_WRITE   = 3'd2,
    OP_HOLD    = 3'd3,
    OP_RELEASE = 3'd4
  } csm_op_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_LOCKED    = 2'd1,
    ERR_NOT_OWNER = 2'd2
  } csm_err_e;

  // Error code for an accepted op given the requester's rights at the accept edge.
  function automatic csm_err_e op_err(input logic [2:0] op, input logic perm, input logic owned);
    csm_err_e err;
    err = ERR_NONE;
    case (op)
      OP_READ, OP_WRITE, OP_HOLD: if (!perm) err = ERR_LOCKED;
      OP_RELEASE:                 if (!owned) err = ERR_NOT_OWNER;
      default:                    err = ERR_NONE;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/csm_lock_table.sv
// Per-address hold flags and owners, with per-port access checks.
`timescale 1ns/1ps
module csm_lock_table
  import csm_pkg::*;
#(
  parameter  int unsigned ADDR_W   = CSM_ADDR_W,
  localparam int unsigned NUM_REGS = 32'(1) << ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic                a_hold,
  input  logic                a_rel,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic                b_hold,
  input  logic                b_rel,
  output logic                a_perm_c,
  output logic                a_owned_c,
  output logic                b_perm_c,
  output logic                b_owned_c,
  output logic [NUM_REGS-1:0] lock_vld,
  output logic [NUM_REGS-1:0] lock_own
);

  logic [NUM_REGS-1:0] vld_q, vld_d;
  logic [NUM_REGS-1:0] own_q, own_d;

  // Access rights: free or self-owned grants access; owner 0 is A, 1 is B.
  always_comb begin
    a_owned_c = vld_q[a_addr] && !own_q[a_addr];
    a_perm_c  = !vld_q[a_addr] || !own_q[a_addr];
    b_owned_c = vld_q[b_addr] && own_q[b_addr];
    b_perm_c  = !vld_q[b_addr] || own_q[b_addr];
  end

  // Apply accepted hold/release commands; arbitration keeps the ports on distinct addresses.
  always_comb begin
    vld_d = vld_q;
    own_d = own_q;
    if (a_hold && a_perm_c) begin
      vld_d[a_addr] = 1'b1;
      own_d[a_addr] = 1'b0;
    end
    if (a_rel && a_owned_c) vld_d[a_addr] = 1'b0;
    if (b_hold && b_perm_c) begin
      vld_d[b_addr] = 1'b1;
      own_d[b_addr] = 1'b1;
    end
    if (b_rel && b_owned_c) vld_d[b_addr] = 1'b0;
  end

  // Lock state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
    end
  end

  assign lock_vld = vld_q;
  assign lock_own = own_q;

endmodule

// File: rtl/csm_shared_mem.sv
// Dual-port shared register file with per-address hold ownership and round-robin conflict arbitration.
`timescale 1ns/1ps
module csm_shared_mem
  import csm_pkg::*;
#(
  parameter  int unsigned ADDR_W   = CSM_ADDR_W,
  parameter  int unsigned DATA_W   = CSM_DATA_W,
  localparam int unsigned NUM_REGS = 32'(1) << ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_op,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic                a_done,
  output logic [DATA_W-1:0]   a_rdata,
  output logic [1:0]          a_err,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [2:0]          b_op,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic                b_done,
  output logic [DATA_W-1:0]   b_rdata,
  output logic [1:0]          b_err,
  output logic [NUM_REGS-1:0] lock_vld,
  output logic [NUM_REGS-1:0] lock_own
);

  logic              ready_q, ready_d;
  logic              rr_q, rr_d;
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic              a_done_q, a_done_d, b_done_q, b_done_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  csm_err_e          a_err_q, a_err_d, b_err_q, b_err_d;

  logic conflict_c, a_acc_c, b_acc_c;
  logic a_perm_c, a_owned_c, b_perm_c, b_owned_c;

  // Same-address requests conflict unless both are reads; the round-robin pointer picks the winner.
  always_comb begin
    ready_d    = 1'b1;
    conflict_c = ready_q && a_valid && b_valid && (a_addr == b_addr)
                 && !((a_op == OP_READ) && (b_op == OP_READ));
    a_ready    = ready_q && !(conflict_c && rr_q);
    b_ready    = ready_q && !(conflict_c && !rr_q);
    a_acc_c    = a_valid && a_ready;
    b_acc_c    = b_valid && b_ready;
    rr_d       = rr_q ^ conflict_c;
  end

  csm_lock_table #(.ADDR_W(ADDR_W)) u_lock (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_addr    (a_addr),
    .a_hold    (a_acc_c && (a_op == OP_HOLD)),
    .a_rel     (a_acc_c && (a_op == OP_RELEASE)),
    .b_addr    (b_addr),
    .b_hold    (b_acc_c && (b_op == OP_HOLD)),
    .b_rel     (b_acc_c && (b_op == OP_RELEASE)),
    .a_perm_c  (a_perm_c),
    .a_owned_c (a_owned_c),
    .b_perm_c  (b_perm_c),
    .b_owned_c (b_owned_c),
    .lock_vld  (lock_vld),
    .lock_own  (lock_own)
  );

  // Register file update and next response for each accepted request.
  always_comb begin
    mem_d     = mem_q;
    a_done_d  = a_acc_c;
    a_rdata_d = '0;
    a_err_d   = ERR_NONE;
    b_done_d  = b_acc_c;
    b_rdata_d = '0;
    b_err_d   = ERR_NONE;
    if (a_acc_c) begin
      a_err_d = op_err(a_op, a_perm_c, a_owned_c);
      if ((a_op == OP_READ) && a_perm_c)  a_rdata_d     = mem_q[a_addr];
      if ((a_op == OP_WRITE) && a_perm_c) mem_d[a_addr] = a_wdata;
    end
    if (b_acc_c) begin
      b_err_d = op_err(b_op, b_perm_c, b_owned_c);
      if ((b_op == OP_READ) && b_perm_c)  b_rdata_d     = mem_q[b_addr];
      if ((b_op == OP_WRITE) && b_perm_c) mem_d[b_addr] = b_wdata;
    end
  end

  // State and response registers; reset discards any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      rr_q      <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) mem_q[i] <= '0;
      a_done_q  <= 1'b0;
      a_rdata_q <= '0;
      a_err_q   <= ERR_NONE;
      b_done_q  <= 1'b0;
      b_rdata_q <= '0;
      b_err_q   <= ERR_NONE;
    end else begin
      ready_q   <= ready_d;
      rr_q      <= rr_d;
      mem_q     <= mem_d;
      a_done_q  <= a_done_d;
      a_rdata_q <= a_rdata_d;
      a_err_q   <= a_err_d;
      b_done_q  <= b_done_d;
      b_rdata_q <= b_rdata_d;
      b_err_q   <= b_err_d;
    end
  end

  assign a_done  = a_done_q;
  assign a_rdata = a_rdata_q;
  assign a_err   = a_err_q;
  assign b_done  = b_done_q;
  assign b_rdata = b_rdata_q;
  assign b_err   = b_err_q;

endmodule

// File: tb/tb_csm_shared_mem.sv
// Self-checking bench for csm_shared_mem: directed scenarios plus randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_csm_shared_mem;
  import csm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid, b_valid, a_ready, b_ready, a_done, b_done;
  logic [2:0] a_op, b_op;
  logic [1:0] a_addr, b_addr, a_err, b_err;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [3:0] lock_vld, lock_own;

  int checks = 0;
  int failures = 0;

  // Reference model: register contents, owner per address (-1 free, 0 A, 1 B), priority port.
  logic [7:0] m_mem [4];
  int         m_own [4];
  int         m_rr;

  csm_shared_mem dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
    .lock_vld(lock_vld), .lock_own(lock_own)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic av, input logic [2:0] aop, input logic [1:0] aad, input logic [7:0] awd,
                       input logic bv, input logic [2:0] bop, input logic [1:0] bad, input logic [7:0] bwd);
    a_valid = av; a_op = aop; a_addr = aad; a_wdata = awd;
    b_valid = bv; b_op = bop; b_addr = bad; b_wdata = bwd;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 2'd0, 8'd0, 1'b0, 3'd0, 2'd0, 8'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic model_apply(input int port, input logic [2:0] op, input int ad, input logic [7:0] wd,
                             output logic [1:0] err, output logic [7:0] rd);
    bit ok;
    ok  = (m_own[ad] < 0) || (m_own[ad] == port);
    err = 2'd0;
    rd  = 8'd0;
    case (op)
      3'd1: if (ok) rd = m_mem[ad]; else err = 2'd1;
      3'd2: if (ok) m_mem[ad] = wd; else err = 2'd1;
      3'd3: if (ok) m_own[ad] = port; else err = 2'd1;
      3'd4: if (m_own[ad] == port) m_own[ad] = -1; else err = 2'd2;
      default: ;
    endcase
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    #1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL rst_a_ready got=%0b exp=0", a_ready); end
    checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL rst_b_ready got=%0b exp=0", b_ready); end
    checks++; if (a_done !== 1'b0 || b_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b%0b exp=00", a_done, b_done); end
    checks++; if (a_rdata !== 8'd0 || a_err !== 2'd0) begin failures++; $display("FAIL rst_a_resp got=%0h/%0d exp=0/0", a_rdata, a_err); end
    checks++; if (lock_vld !== 4'b0000) begin failures++; $display("FAIL rst_lock_vld got=%b exp=0000", lock_vld); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_pre_edge got=%0b exp=0", a_ready); end
    tick();
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_rise got=%0b%0b exp=11", a_ready, b_ready); end
  endtask

  task automatic test_write_read();
    do_reset();
    drive(1'b1, OP_WRITE, 2'd1, 8'hA5, 1'b0, OP_NOP, 2'd0, 8'd0);
    tick();
    checks++; if (a_done !== 1'b1 || a_err !== 2'd0) begin failures++; $display("FAIL wr_done got=%0b/%0d exp=1/0", a_done, a_err); end
    drive(1'b1, OP_READ, 2'd1, 8'h00, 1'b0, OP_NOP, 2'd0, 8'd0);
    tick();
    checks++; if (a_done !== 1'b1 || a_rdata !== 8'hA5 || a_err !== 2'd0) begin failures++; $display("FAIL rd_after_wr got=%0b/%0h/%0d exp=1/a5/0", a_done, a_rdata, a_err); end
    idle();
    tick();
    checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%0b exp=0", a_done); end
  endtask

  task automatic test_hold_block();
    do_reset();
    drive(1'b1, OP_HOLD, 2'd2, 8'd0, 1'b0, OP_NOP, 2'd0, 8'd0);
    tick();
    checks++; if (a_err !== 2'd0) begin failures++; $display("FAIL hold_a got=%0d exp=0", a_err); end
    drive(1'b0, OP_NOP, 2'd0, 8'd0, 1'b1, OP_READ, 2'd2, 8'd0);
    tick();
    checks++; if (b_done !== 1'b1 || b_err !== 2'd1 || b_rdata !== 8'd0) begin failures++; $display("FAIL b_read_locked got=%0b/%0d/%0h exp=1/1/0", b_done, b_err, b_rdata); end
    drive(1'b0, OP_NOP, 2'd0, 8'd0, 1'b1, OP_WRITE, 2'd2, 8'hFF);
    tick();
    checks++; if (b_err !== 2'd1) begin failures++; $display("FAIL b_write_locked got=%0d exp=1", b_err); end
    checks++; if (lock_vld[2] !== 1'b1 || lock_own[2] !== 1'b0) begin failures++; $display("FAIL lock2_state got=%0b/%0b exp=1/0", lock_vld[2], lock_own[2]); end
    drive(1'b1, OP_READ, 2'd2, 8'd0, 1'b0, OP_NOP, 2'd0, 8'd0);
    tick();
    checks++; if (a_rdata !== 8'd0 || a_err !== 2'd0) begin failures++; $display("FAIL reg2_unchanged got=%0h/%0d exp=0/0", a_rdata, a_err); end
  endtask

  task automatic test_hold_release();
    do_reset();
    drive(1'b1, OP_WRITE, 2'd2, 8'h5A, 1'b0, OP_NOP, 2'd0, 8'd0);
    tick();
    drive(1'b1, OP_HOLD, 2'd2, 8'd0, 1'b0, OP_NOP, 2'd0, 8'd0);
    tick();
    checks++; if (a_err !== 2'd0 || lock_vld[2] !== 1'b1) begin failures++; $display("FAIL hr_hold got=%0d/%0b exp=0/1", a_err, lock_vld[2]); end
    drive(1'b1, OP_RELEASE, 2'd2, 8'd0, 1'b0, OP_NOP, 2'd0, 8'd0);
    tick();
    checks++; if (a_err !== 2'd0 || lock_vld[2] !== 1'b0) begin failures++; $display("FAIL hr_release got=%0d/%0b exp=0/0", a_err, lock_vld[2]); end
    drive(1'b0, OP_NOP, 2'd0, 8'd0, 1'b1, OP_READ, 2'd2, 8'd0);
    tick();
    checks++; if (b_err !== 2'd0 || b_rdata !== 8'h5A) begin failures++; $display("FAIL hr_b_read got=%0d/%0h exp=0/5a", b_err, b_rdata); end
  endtask

  task automatic test_conflict_write();
    do_reset();
    drive(1'b1, OP_WRITE, 2'd3, 8'h00, 1'b1, OP_WRITE, 2'd3, 8'hFF);
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin failures++; $display("FAIL cw_ready1 got=%0b%0b exp=10", a_ready, b_ready); end
    tick();
    checks++; if (a_done !== 1'b1 || b_done !== 1'b0) begin failures++; $display("FAIL cw_done1 got=%0b%0b exp=10", a_done, b_done); end
    drive(1'b0, OP_NOP, 2'd0, 8'd0, 1'b1, OP_WRITE, 2'd3, 8'hFF);
    #1;
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL cw_b_ready got=%0b exp=1", b_ready); end
    tick();
    checks++; if (b_done !== 1'b1 || b_err !== 2'd0) begin failures++; $display("FAIL cw_b_done got=%0b/%0d exp=1/0", b_done, b_err); end
    drive(1'b1, OP_READ, 2'd3, 8'd0, 1'b0, OP_NOP, 2'd0, 8'd0);
    tick();
    checks++; if (a_rdata !== 8'hFF) begin failures++; $display("FAIL cw_read3 got=%0h exp=ff", a_rdata); end
    drive(1'b1, OP_WRITE, 2'd0, 8'h11, 1'b1, OP_WRITE, 2'd0, 8'h22);
    #1;
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin failures++; $display("FAIL cw_ready2 got=%0b%0b exp=01", a_ready, b_ready); end
    tick();
    checks++; if (a_done !== 1'b0 || b_done !== 1'b1) begin failures++; $display("FAIL cw_done2 got=%0b%0b exp=01", a_done, b_done); end
    drive(1'b1, OP_WRITE, 2'd0, 8'h11, 1'b0, OP_NOP, 2'd0, 8'd0);
    tick();
    checks++; if (a_done !== 1'b1) begin failures++; $display("FAIL cw_a_late got=%0b exp=1", a_done); end
    drive(1'b1, OP_READ, 2'd0, 8'd0, 1'b0, OP_NOP, 2'd0, 8'd0);
    tick();
    checks++; if (a_rdata !== 8'h11) begin failures++; $display("FAIL cw_read0 got=%0h exp=11", a_rdata); end
  endtask

  task automatic test_conflict_hold();
    do_reset();
    drive(1'b1, OP_HOLD, 2'd0, 8'd0, 1'b1, OP_HOLD, 2'd0, 8'd0);
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin failures++; $display("FAIL ch_ready got=%0b%0b exp=10", a_ready, b_ready); end
    tick();
    checks++; if (a_done !== 1'b1 || a_err !== 2'd0) begin failures++; $display("FAIL ch_a got=%0b/%0d exp=1/0", a_done, a_err); end
    drive(1'b0, OP_NOP, 2'd0, 8'd0, 1'b1, OP_HOLD, 2'd0, 8'd0);
    tick();
    checks++; if (b_done !== 1'b1 || b_err !== 2'd1) begin failures++; $display("FAIL ch_b got=%0b/%0d exp=1/1", b_done, b_err); end
    drive(1'b0, OP_NOP, 2'd0, 8'd0, 1'b1, OP_RELEASE, 2'd0, 8'd0);
    tick();
    checks++; if (b_err !== 2'd2) begin failures++; $display("FAIL ch_b_release got=%0d exp=2", b_err); end
    checks++; if (lock_vld[0] !== 1'b1 || lock_own[0] !== 1'b0) begin failures++; $display("FAIL ch_lock0 got=%0b/%0b exp=1/0", lock_vld[0], lock_own[0]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, OP_HOLD, 2'd0, 8'd0, 1'b0, OP_NOP, 2'd0, 8'd0);
    tick();
    drive(1'b1, OP_WRITE, 2'd1, 8'h3C, 1'b0, OP_NOP, 2'd0, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle();
    #1;
    checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL rm_no_done got=%0b exp=0", a_done); end
    checks++; if (lock_vld !== 4'b0000) begin failures++; $display("FAIL rm_locks got=%b exp=0000", lock_vld); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(1'b1, OP_READ, 2'd1, 8'd0, 1'b0, OP_NOP, 2'd0, 8'd0);
    tick();
    checks++; if (a_done !== 1'b1 || a_rdata !== 8'd0) begin failures++; $display("FAIL rm_read1 got=%0b/%0h exp=1/0", a_done, a_rdata); end
    idle();
  endtask

  task automatic test_random();
    logic av, bv, conf, ear, ebr, aacc, bacc;
    logic [2:0] aop, bop;
    logic [1:0] aa, ba, aerr, berr;
    logic [7:0] awd, bwd, ard, brd;
    do_reset();
    for (int k = 0; k < 4; k++) begin m_mem[k] = 8'd0; m_own[k] = -1; end
    m_rr = 0;
    for (int n = 0; n < 400; n++) begin
      av  = ($urandom_range(0, 3) != 0);
      bv  = ($urandom_range(0, 3) != 0);
      aop = 3'($urandom_range(0, 7));
      bop = 3'($urandom_range(0, 7));
      aa  = 2'($urandom_range(0, 3));
      ba  = 2'($urandom_range(0, 3));
      awd = 8'($urandom);
      bwd = 8'($urandom);
      drive(av, aop, aa, awd, bv, bop, ba, bwd);
      #1;
      conf = av && bv && (aa == ba) && !(aop == 3'd1 && bop == 3'd1);
      ear  = !(conf && m_rr == 1);
      ebr  = !(conf && m_rr == 0);
      checks++; if (a_ready !== ear) begin failures++; $display("FAIL rnd_a_ready n=%0d got=%0b exp=%0b", n, a_ready, ear); end
      checks++; if (b_ready !== ebr) begin failures++; $display("FAIL rnd_b_ready n=%0d got=%0b exp=%0b", n, b_ready, ebr); end
      aacc = av && ear;
      bacc = bv && ebr;
      aerr = 2'd0; ard = 8'd0; berr = 2'd0; brd = 8'd0;
      if (aacc) model_apply(0, aop, int'(aa), awd, aerr, ard);
      if (bacc) model_apply(1, bop, int'(ba), bwd, berr, brd);
      if (conf) m_rr = 1 - m_rr;
      tick();
      checks++; if (a_done !== aacc) begin failures++; $display("FAIL rnd_a_done n=%0d got=%0b exp=%0b", n, a_done, aacc); end
      checks++; if (b_done !== bacc) begin failures++; $display("FAIL rnd_b_done n=%0d got=%0b exp=%0b", n, b_done, bacc); end
      if (aacc) begin
        checks++; if (a_err !== aerr || a_rdata !== ard) begin failures++; $display("FAIL rnd_a_resp n=%0d got=%0d/%0h exp=%0d/%0h", n, a_err, a_rdata, aerr, ard); end
      end
      if (bacc) begin
        checks++; if (b_err !== berr || b_rdata !== brd) begin failures++; $display("FAIL rnd_b_resp n=%0d got=%0d/%0h exp=%0d/%0h", n, b_err, b_rdata, berr, brd); end
      end
      for (int k = 0; k < 4; k++) begin
        checks++; if (lock_vld[k] !== (m_own[k] >= 0)) begin failures++; $display("FAIL rnd_lock_vld n=%0d addr=%0d got=%0b exp=%0b", n, k, lock_vld[k], (m_own[k] >= 0)); end
        if (m_own[k] >= 0) begin
          checks++; if (lock_own[k] !== (m_own[k] == 1)) begin failures++; $display("FAIL rnd_lock_own n=%0d addr=%0d got=%0b exp=%0b", n, k, lock_own[k], (m_own[k] == 1)); end
        end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_hold_block();
    test_hold_release();
    test_conflict_write();
    test_conflict_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csm_shared_mem.md
Name: csm_shared_mem

Overview:
- Dual-port shared memory with per-address hold (lock) semantics. This is the CSM design under test that the bench BFM drives.
- Processors A and B each issue read, write, hold and release operations to a small register file.
- Arbitrates same-cycle conflicts between the ports.
- Enforces ownership of held addresses and reports violations through a per-port error code.

Parameters:
- ADDR_W, 2, address width; register count NUM_REGS = 2**ADDR_W (4).
- DATA_W, 8, data width of each register.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  port A request valid.
- a_ready  out  1  port A can accept a request this cycle.
- a_op  in  3  port A operation (csm_op_e).
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_done  out  1  one-cycle pulse; port A response valid.
- a_rdata  out  DATA_W  port A read data; valid with a_done.
- a_err  out  2  port A error code (csm_err_e); valid with a_done.
- b_valid, b_ready, b_op, b_addr, b_wdata, b_done, b_rdata, b_err: identical set for port B.
- lock_vld  out  NUM_REGS  per-address held flag (observability).
- lock_own  out  NUM_REGS  per-address owner, 0 = A, 1 = B; meaningful only where lock_vld = 1.

Behaviour:
- Reset, while rst_n is low:
  - All registers are 0; all locks are cleared; the round-robin pointer selects A.
  - x_done = 0, x_rdata = 0, x_err = ERR_NONE, x_ready = 0.
  - x_ready rises 1 on the first clock edge after rst_n deasserts.
- Reset asserted mid-operation: any in-flight request is discarded and no done pulse is produced.
- Handshake:
  - A request is accepted on a rising edge where x_valid && x_ready.
  - The response (x_done, x_rdata, x_err) appears exactly 1 cycle after acceptance and is held for one cycle only.
  - Back-to-back acceptance is allowed every cycle.
- OP_NOP is accepted, produces a done pulse, and has no effect.
- Operation semantics (evaluated against lock state at the accept edge):
  - READ: if the address is free or owned by the requester, return the register value with ERR_NONE. If it is held by the other port, return rdata = 0 with ERR_LOCKED.
  - WRITE: if the address is free or owned, update the register at the accept edge with ERR_NONE. If it is held by the other port, leave the register unchanged and report ERR_LOCKED.
  - HOLD:
    - Free address: set lock_vld and the owner; ERR_NONE.
    - Already owned by the requester: no-op, ERR_NONE.
    - Held by the other port: ERR_LOCKED.
  - RELEASE: if owned by the requester, clear the lock with ERR_NONE. If the address is free or held by the other port, there is no change and the result is ERR_NOT_OWNER.
  - A port may hold any number of addresses simultaneously.
- Read-after-write from the same port in consecutive cycles returns the new data (no bypass needed; the write commits at the accept edge).
- Conflict arbitration, for same-cycle valid requests to the same address:
  - Two READs never conflict; both are accepted.
  - Any other pairing conflicts.
  - For a conflict, combinational ready is computed from the round-robin pointer: the winner's ready is 1 and the loser's ready is 0.
  - The loser is accepted the next cycle if it is still valid, and is evaluated against the state updated by the winner.
  - The pointer toggles after every conflict, giving alternating priority.
  - Requests to different addresses never conflict; both are accepted in the same cycle.
  - Example: A HOLD and B HOLD to the same free address, pointer = A. A gets the lock in cycle n. B is accepted in cycle n+1 and returns ERR_LOCKED.
- Ready is otherwise 1 whenever out of reset.

Decomposition:
- csm_pkg:
  - csm_op_e {OP_NOP=0, OP_READ=1, OP_WRITE=2, OP_HOLD=3, OP_RELEASE=4}; codes 5–7 behave as NOP.
  - csm_err_e {ERR_NONE=0, ERR_LOCKED=1, ERR_NOT_OWNER=2}.
  - Default ADDR_W and DATA_W constants.
- Sub-module csm_lock_table holds the per-address lock_vld/lock_own storage and its update logic. It takes both ports' accepted hold/release commands and returns a permission check per port.
- Arbitration, the register file and the response registers live in the top level.

Test Plan:
- Reset, then A WRITE addr 1 data 0xA5, then A READ addr 1 -> first done with ERR_NONE; second done with rdata 0xA5, ERR_NONE.
- A HOLD addr 2, then B READ addr 2 and B WRITE addr 2 data 0xFF -> B err ERR_LOCKED on both, B rdata 0, register 2 unchanged; lock_vld[2] = 1, lock_own[2] = 0.
- A HOLD 2, A RELEASE 2, B READ 2 -> all ERR_NONE; lock_vld[2] = 0 after the release.
- Same cycle A WRITE 3 data 0x00 and B WRITE 3 data 0xFF right after reset:
  - Cycle n: a_ready = 1, b_ready = 0.
  - Cycle n+1: B accepted.
  - A subsequent READ 3 returns 0xFF.
  - The next conflict gives B priority.
- Same cycle A HOLD 0 and B HOLD 0 (pointer = A) -> A ERR_NONE; B accepted one cycle later with ERR_LOCKED. Then B RELEASE 0 -> ERR_NOT_OWNER with the lock unchanged.
- Assert rst_n low in the cycle after A WRITE 1 data 0x3C is accepted, with A holding addr 0 -> no a_done pulse, register 1 reads 0 after reset, lock_vld = 0000.
